// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM state encoding and redirect-slot types for the fetch sequencer.
package fetch_ctrl_pkg;

  localparam int FULLW = 32;

  typedef enum logic [1:0] {
    FC_LATCH = 2'd0,
    FC_ISSUE = 2'd1,
    FC_HOLD  = 2'd2,
    FC_ERR   = 2'd3
  } fc_state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_JMP  = 2'd2
  } redir_kind_e;

  typedef struct packed {
    redir_kind_e      kind;
    logic [FULLW-1:0] val;
  } redir_t;

  // A jump replaces anything held; a branch only replaces an older branch.
  function automatic redir_t merge_redirect(input redir_t held, input redir_t fresh);
    if (fresh.kind == RD_JMP) return fresh;
    if (fresh.kind == RD_BR && held.kind != RD_JMP) return fresh;
    return held;
  endfunction

endpackage

// File: rtl/pc32.sv
// Program counter: counter updates only when mod_en is set; iaddrout latches the counter on r_en.
module pc32
  import fetch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             mod_en,
  input  logic             r_en,
  input  logic             we,
  input  logic [FULLW-1:0] wd,
  input  logic             ib,
  input  logic [FULLW-1:0] bv,
  output logic [FULLW-1:0] iaddrout
);

  logic [FULLW-1:0] ctr;

  always_ff @(posedge clk) begin
    if (mod_en) begin
      if (reset)   ctr <= '0;
      else if (we) ctr <= wd;
      else if (ib) ctr <= ctr + bv + FULLW'(8);
      else         ctr <= ctr + FULLW'(4);
    end
    if (mod_en && reset) iaddrout <= '0;
    else if (r_en)       iaddrout <= ctr;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Multicycle fetch sequencer: steers pc32, runs the imem request/ack handshake and
// presents fetched words to decode, applying execute-stage redirects in order.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_take,
  input  logic [FULLW-1:0] br_off,
  input  logic             jmp_en,
  input  logic [FULLW-1:0] jmp_addr,
  input  logic             imem_ack,
  input  logic [FULLW-1:0] imem_rdata,
  input  logic [FULLW-1:0] pc_in,
  output logic             pc_reset,
  output logic             pc_mod_en,
  output logic             pc_r_en,
  output logic             pc_we,
  output logic             pc_ib,
  output logic [FULLW-1:0] pc_wd,
  output logic [FULLW-1:0] pc_bv,
  output logic             imem_req,
  output logic [FULLW-1:0] imem_addr,
  output logic             if_valid,
  output logic [FULLW-1:0] if_instr,
  output logic [FULLW-1:0] if_pc,
  output logic             fetch_err
);

  fc_state_e         state;
  logic [WAIT_W-1:0] wait_cnt;
  redir_t            pending;
  redir_t            incoming;
  redir_t            merged;
  redir_t            apply;
  logic              has_incoming;

  always_comb begin
    incoming = '0;
    if (jmp_en) begin
      incoming.kind = RD_JMP;
      incoming.val  = jmp_addr;
    end else if (br_take) begin
      incoming.kind = RD_BR;
      incoming.val  = br_off;
    end
  end

  assign has_incoming = (incoming.kind != RD_NONE);
  // A redirect landing on the ack cycle also makes the returned word stale,
  // so it is folded into the pending slot before the ack is acted upon.
  assign merged = merge_redirect(pending, incoming);

  always_comb begin
    apply     = '0;
    pc_reset  = 1'b0;
    pc_mod_en = 1'b0;
    pc_r_en   = 1'b0;
    pc_we     = 1'b0;
    pc_ib     = 1'b0;
    pc_wd     = '0;
    pc_bv     = '0;
    imem_addr = '0;
    if (reset) begin
      pc_reset  = 1'b1;
      pc_mod_en = 1'b1;
    end else if (state != FC_ERR) begin
      case (state)
        FC_LATCH: begin
          pc_r_en = 1'b1;
          apply   = incoming;
        end
        FC_ISSUE: begin
          imem_addr = pc_in;
          if (imem_ack) apply = merged;
        end
        FC_HOLD: begin
          apply = incoming;
          if (!has_incoming && !stall) pc_mod_en = 1'b1;
        end
        default: ;
      endcase
      if (apply.kind != RD_NONE) pc_mod_en = 1'b1;
      pc_we = (apply.kind == RD_JMP);
      pc_ib = (apply.kind == RD_BR);
      pc_wd = (apply.kind == RD_JMP) ? apply.val : jmp_addr;
      pc_bv = (apply.kind == RD_BR)  ? apply.val : br_off;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FC_LATCH;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
      pending   <= '0;
    end else begin
      case (state)
        FC_LATCH: begin
          // A redirect here updates the counter while iaddrout captures the old value, so re-latch.
          if (!has_incoming) begin
            state    <= FC_ISSUE;
            wait_cnt <= '0;
            imem_req <= 1'b1;
            pending  <= '0;
          end
        end
        FC_ISSUE: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            pending  <= '0;
            if (merged.kind == RD_NONE) begin
              if_instr <= imem_rdata;
              if_pc    <= pc_in;
              if_valid <= 1'b1;
              state    <= FC_HOLD;
            end else begin
              state <= FC_LATCH;
            end
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            pending   <= '0;
            state     <= FC_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            pending  <= merged;
          end
        end
        FC_HOLD: begin
          if (has_incoming || !stall) begin
            if_valid <= 1'b0;
            state    <= FC_LATCH;
          end
        end
        FC_ERR: begin
          fetch_err <= 1'b1;
        end
        default: state <= FC_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl driving a real pc32; expected fetch addresses come from an
// architectural next-address model (sequential +4, branch base+off+8, jump target).
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             reset, stall, br_take, jmp_en, imem_ack;
  logic [FULLW-1:0] br_off, jmp_addr, imem_rdata, pc_in, pc_wd, pc_bv;
  logic [FULLW-1:0] imem_addr, if_instr, if_pc;
  logic             pc_reset, pc_mod_en, pc_r_en, pc_we, pc_ib;
  logic             imem_req, if_valid, fetch_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] F;  // address the next delivered instruction must carry

  always #5 clk = ~clk;

  fetch_ctrl #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_take(br_take), .br_off(br_off),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_in(pc_in), .pc_reset(pc_reset), .pc_mod_en(pc_mod_en), .pc_r_en(pc_r_en),
    .pc_we(pc_we), .pc_ib(pc_ib), .pc_wd(pc_wd), .pc_bv(pc_bv), .imem_req(imem_req),
    .imem_addr(imem_addr), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  pc32 u_pc (
    .clk(clk), .reset(pc_reset), .mod_en(pc_mod_en), .r_en(pc_r_en), .we(pc_we),
    .wd(pc_wd), .ib(pc_ib), .bv(pc_bv), .iaddrout(pc_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 none, 1 branch, 2 jump, 3 jump and branch together
  task automatic drive_redir(input int k, input logic [31:0] o, input logic [31:0] t);
    br_take  = (k == 1 || k == 3);
    jmp_en   = (k >= 2);
    br_off   = o;
    jmp_addr = t;
  endtask

  function automatic logic [31:0] redir_target(input int k, input logic [31:0] base,
                                               input logic [31:0] o, input logic [31:0] t);
    return (k >= 2) ? t : base + o + 32'd8;
  endfunction

  function automatic logic [31:0] rand_off();
    logic [31:0] r;
    r = $urandom;
    return {{20{r[11]}}, r[11:2], 2'b00};
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'h0000_FFFC;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1; stall = 1'b0; imem_ack = 1'b0;
    drive_redir(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      #1 check("rst_pc_ctl", 32'({pc_reset, pc_mod_en}), 32'd3);
      tick();
    end
    check("rst_valid", 32'(if_valid), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_err", 32'(fetch_err), 0);
    check("rst_pc", if_pc, 0);
    reset = 1'b0;
    F = 32'd0;
  endtask

  // Entered on a LATCH cycle; returns on the next LATCH cycle.
  task automatic fetch_one(input int d, input int s, input int lk, input int ik, input bit irnd,
                           input int hk, input logic [31:0] off, input logic [31:0] tgt,
                           input logic [31:0] dat);
    int          pk;
    int          k;
    logic [31:0] pnext, poff, o, t;
    if (lk != 0) begin
      drive_redir(lk, off, tgt);
      #1;
      check("latch_mod", 32'(pc_mod_en), 1);
      check("latch_ren", 32'(pc_r_en), 1);
      F = redir_target(lk, F, off, tgt);
      tick();
      drive_redir(0, 0, 0);
    end
    #1 check("latch_req", 32'(imem_req), 0);
    tick();
    check("issue_req", 32'(imem_req), 1);
    check("issue_addr", imem_addr, F);
    pk = 0; pnext = 0; poff = 0;
    for (int j = 0; j < d; j++) begin
      k = 0; o = off; t = tgt;
      if (j == 0) k = ik;
      else if (irnd && $urandom_range(3) == 0) begin
        k = $urandom_range(1, 3); o = rand_off(); t = rand_addr();
      end
      drive_redir(k, o, t);
      if (k >= 2) begin
        pk = 2; pnext = t;
      end else if (k == 1 && pk != 2) begin
        pk = 1; pnext = F + o + 32'd8; poff = o;
      end
      #1 check("issue_nomod", 32'(pc_mod_en), 0);
      tick();
      drive_redir(0, 0, 0);
      check("issue_req_held", 32'(imem_req), 1);
      check("issue_addr_stable", imem_addr, F);
      check("issue_err", 32'(fetch_err), 0);
    end
    imem_ack = 1'b1; imem_rdata = dat;
    #1;
    check("ack_mod", 32'(pc_mod_en), 32'(pk != 0));
    check("ack_we", 32'(pc_we), 32'(pk == 2));
    check("ack_ib", 32'(pc_ib), 32'(pk == 1));
    if (pk == 2) check("ack_wd", pc_wd, pnext);
    if (pk == 1) check("ack_bv", pc_bv, poff);
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    check("ack_req_drop", 32'(imem_req), 0);
    if (pk != 0) begin
      check("discard_valid", 32'(if_valid), 0);
      F = pnext;
      return;
    end
    check("valid", 32'(if_valid), 1);
    check("if_pc", if_pc, F);
    check("if_instr", if_instr, dat);
    check("hold_err", 32'(fetch_err), 0);
    stall = 1'b1;
    for (int j = 0; j < s; j++) begin
      #1 check("stall_nomod", 32'(pc_mod_en), 0);
      tick();
      check("stall_valid", 32'(if_valid), 1);
      check("stall_pc", if_pc, F);
      check("stall_instr", if_instr, dat);
    end
    stall = (hk != 0) ? 1'($urandom_range(1)) : 1'b0;
    drive_redir(hk, off, tgt);
    #1;
    check("hold_mod", 32'(pc_mod_en), 1);
    check("hold_we", 32'(pc_we), 32'(hk >= 2));
    check("hold_ib", 32'(pc_ib), 32'(hk == 1));
    if (hk == 1) check("hold_bv", pc_bv, off);
    if (hk >= 2) check("hold_wd", pc_wd, tgt);
    F = (hk == 0) ? F + 32'd4 : redir_target(hk, F, off, tgt);
    tick();
    drive_redir(0, 0, 0);
    stall = 1'b0;
    check("hold_exit_valid", 32'(if_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, s, lk, ik, hk;
    reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    drive_redir(0, 0, 0);
    do_reset(3);

    fetch_one(0, 0, 0, 0, 0, 0, 0, 0, 32'hE3A00001);
    fetch_one(5, 4, 0, 0, 0, 0, 0, 0, $urandom);
    fetch_one(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    fetch_one(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    fetch_one(0, 1, 0, 0, 0, 1, 32'h20, 0, $urandom);
    fetch_one(2, 0, 0, 3, 0, 0, 32'h20, 32'h100, $urandom);
    fetch_one(15, 0, 0, 0, 0, 0, 0, 0, $urandom);
    fetch_one(0, 0, 1, 0, 0, 2, 32'h40, 32'h300, $urandom);
    fetch_one(3, 0, 0, 1, 0, 0, 32'hFFFF_FFF0, 0, $urandom);
    fetch_one(1, 0, 0, 0, 0, 0, 0, 0, $urandom);

    // Reset while a request is outstanding; the late ack must be ignored.
    tick();
    check("mr_req", 32'(imem_req), 1);
    tick();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1 check("mr_pc_ctl", 32'({pc_reset, pc_mod_en}), 32'd3);
    tick();
    check("mr_req_drop", 32'(imem_req), 0);
    check("mr_valid", 32'(if_valid), 0);
    reset = 1'b0; F = 32'd0;
    #1 check("mr_latch_ren", 32'(pc_r_en), 1);
    check("mr_latch_nomod", 32'(pc_mod_en), 0);
    tick();
    imem_ack = 1'b0;
    check("mr_issue_req", 32'(imem_req), 1);
    check("mr_issue_addr", imem_addr, 0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("mr_valid2", 32'(if_valid), 1);
    check("mr_if_pc", if_pc, 0);
    check("mr_if_instr", if_instr, 32'h1234_5678);
    tick();
    F = 32'd4;
    check("mr_exit", 32'(if_valid), 0);

    for (int n = 0; n < 60; n++) begin
      d  = $urandom_range(0, 6);
      s  = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
      lk = ($urandom_range(5) == 0) ? $urandom_range(1, 3) : 0;
      ik = (d > 0 && $urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
      hk = ($urandom_range(2) == 0) ? $urandom_range(1, 3) : 0;
      fetch_one(d, s, lk, ik, 1'b1, hk, rand_off(), rand_addr(), $urandom);
    end

    // Imem timeout: sixteen ack-less ISSUE cycles lead to the sticky error.
    tick();
    for (int j = 0; j < 16; j++) begin
      check("to_req", 32'(imem_req), 1);
      tick();
    end
    check("to_err", 32'(fetch_err), 1);
    check("to_req_off", 32'(imem_req), 0);
    for (int j = 0; j < 4; j++) begin
      drive_redir(3, 32'h40, 32'h200);
      imem_ack = 1'b1;
      #1;
      check("err_mod", 32'(pc_mod_en), 0);
      check("err_ren", 32'(pc_r_en), 0);
      check("err_wd", pc_wd, 0);
      check("err_addr", imem_addr, 0);
      tick();
      check("err_sticky", 32'(fetch_err), 1);
      check("err_valid", 32'(if_valid), 0);
      check("err_req", 32'(imem_req), 0);
    end
    drive_redir(0, 0, 0);
    imem_ack = 1'b0;
    do_reset(2);
    fetch_one(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    fetch_one(1, 0, 0, 0, 0, 0, 0, 0, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
